imem_loader: RTL and testbench

Writes a program image into instruction memory ahead of execution of the single-cycle RISC-V core. It is the write side of the instruction-memory interface that the fetch stage reads.
- It accepts a byte stream over a valid/ready handshake and packs the bytes into little-endian 32-bit words.
- It issues one word write per packed word at incrementing, word-aligned addresses.
- It holds the CPU while a load is in progress.

---
 rtl/imem_loader_pkg.sv | 23 ++
 rtl/imem_byte_packer.sv | 38 +++
 rtl/imem_loader.sv | 132 +++++++++++++
 tb/tb_imem_loader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader: state encoding, length field width, lane count.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } loader_state_t;

    localparam int LEN_W  = 16;
    localparam int LANES  = 4;
    localparam int LANE_W = $clog2(LANES);

    // A session is open (stream bytes are wanted) from LEN0 up to CSUM.
    function automatic logic is_active(input loader_state_t s);
        return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Packs a byte stream into little-endian words; word_full marks the byte that completes a word.
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               byte_en,
    input  logic [7:0]         byte_data,
    output logic [8*LANES-1:0] packed_word,
    output logic               word_full
);

    logic [LANE_W-1:0]  lane_q;
    logic [8*LANES-1:0] data_q;

    // The completing byte bypasses the register so the word is usable in the same cycle.
    always_comb begin
        packed_word = data_q;
        packed_word[8*(LANES-1) +: 8] = byte_data;
    end

    assign word_full = byte_en && (lane_q == LANE_W'(LANES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= '0;
            data_q <= '0;
        end else if (clear) begin
            lane_q <= '0;
            data_q <= '0;
        end else if (byte_en) begin
            data_q[8*lane_q +: 8] <= byte_data;
            lane_q                <= lane_q + 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory, holding the CPU meanwhile.
// Define IMEM_LOADER_CSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        wr_en_o,
    output logic [31:0] wr_addr_o,
    output logic [31:0] wr_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o
);

    localparam int          CNT_W     = ADDR_W + 1;
    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

    loader_state_t    state_q;
    loader_state_t    state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_full;
    logic [CNT_W-1:0] word_cnt_q;
    logic [31:0]      packed_word;
    logic             accept;
    logic             session_clear;
    logic             pack_en;
    logic             word_full;
    logic             last_word;
    logic             len_bad;

    assign accept        = byte_valid_i && byte_ready_o;
    assign session_clear = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
    assign pack_en       = accept && (state_q == ST_DATA);
    assign len_full      = {byte_data_i, len_q[7:0]};
    assign len_bad       = (len_full == '0) || (32'(len_full) > MAX_WORDS);
    assign last_word     = (32'(word_cnt_q) + 32'd1) == 32'(len_q);

    imem_byte_packer u_packer (
        .clk         (clk_i),
        .rst_n       (rst_n_i),
        .clear       (session_clear),
        .byte_en     (pack_en),
        .byte_data   (byte_data_i),
        .packed_word (packed_word),
        .word_full   (word_full)
    );

`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0] csum_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            csum_q <= '0;
        end else if (session_clear) begin
            csum_q <= '0;
        end else if (pack_en) begin
            csum_q <= csum_q ^ byte_data_i;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_i) state_d = ST_LEN0;
            end
            ST_LEN0: begin
                if (accept) state_d = ST_LEN1;
            end
            ST_LEN1: begin
                if (accept) state_d = len_bad ? ST_ERR : ST_DATA;
            end
            ST_DATA: begin
`ifdef IMEM_LOADER_CSUM_EN
                if (word_full && last_word) state_d = ST_CSUM;
`else
                if (word_full && last_word) state_d = ST_DONE;
`endif
            end
`ifdef IMEM_LOADER_CSUM_EN
            ST_CSUM: begin
                if (accept) state_d = (byte_data_i == csum_q) ? ST_DONE : ST_ERR;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Status outputs follow the next state so they line up with the state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            word_cnt_q   <= '0;
            byte_ready_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
            wr_en_o      <= 1'b0;
            wr_addr_o    <= '0;
            wr_data_o    <= '0;
        end else begin
            state_q      <= state_d;
            byte_ready_o <= is_active(state_d);
            busy_o       <= is_active(state_d);
            done_o       <= (state_d == ST_DONE);
            error_o      <= (state_d == ST_ERR);
            wr_en_o      <= word_full;

            if (accept && (state_q == ST_LEN0)) len_q[7:0]  <= byte_data_i;
            if (accept && (state_q == ST_LEN1)) len_q[15:8] <= byte_data_i;

            if (session_clear) begin
                word_cnt_q <= '0;
            end else if (word_full) begin
                word_cnt_q <= word_cnt_q + 1'b1;
                wr_addr_o  <= BASE_ADDR + (32'(word_cnt_q) << 2);
                wr_data_o  <= packed_word;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: stream-position reference model plus directed and random sessions.
// Define IMEM_LOADER_CSUM_EN for both bench and design to cover the checksum build.
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int          ADDR_W    = 10;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
`ifdef IMEM_LOADER_CSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b1;
    logic        start      = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data  = 8'h00;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        error;

    imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .start_i      (start),
        .byte_valid_i (byte_valid),
        .byte_data_i  (byte_data),
        .byte_ready_o (byte_ready),
        .wr_en_o      (wr_en),
        .wr_addr_o    (wr_addr),
        .wr_data_o    (wr_data),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error)
    );

    always #5 clk = ~clk;

    int          nCompared   = 0;
    int          nMismatched = 0;
    bit          checkEn     = 1'b0;
    int          cyc         = 0;
    int          startCyc    = 0;
    logic [7:0]  stream[$];
    logic [31:0] payload[$];
    logic [31:0] logAddr[$];
    logic [31:0] logData[$];
    int          logCyc[$];

    // Reference model: tracks position in the byte stream rather than any state encoding.
    bit          mActive = 1'b0;
    int          mCnt    = 0;
    int          mN      = 0;
    logic [7:0]  mCsum   = 8'h00;
    logic [31:0] mWord   = 32'h0;
    bit          mDone   = 1'b0;
    bit          mErr    = 1'b0;
    bit          mWrEn   = 1'b0;
    logic [31:0] mWrAddr = 32'h0;
    logic [31:0] mWrData = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mActive = 1'b0; mCnt = 0; mN = 0; mCsum = 8'h00; mWord = 32'h0;
            mDone = 1'b0; mErr = 1'b0; mWrEn = 1'b0; mWrAddr = 32'h0; mWrData = 32'h0;
        end else begin
            mWrEn = 1'b0;
            if (!mActive) begin
                if (start) begin
                    mActive = 1'b1; mCnt = 0; mDone = 1'b0; mErr = 1'b0; mCsum = 8'h00; mWord = 32'h0;
                end
            end else if (byte_valid) begin
                if (mCnt == 0) begin
                    mN = int'(byte_data);
                end else if (mCnt == 1) begin
                    mN = mN + 256 * int'(byte_data);
                    if (mN == 0 || mN > (1 << ADDR_W)) begin
                        mActive = 1'b0; mErr = 1'b1;
                    end
                end else if (mCnt < 2 + 4 * mN) begin
                    int p;
                    p = mCnt - 2;
                    mWord[8*(p%4) +: 8] = byte_data;
                    mCsum = mCsum ^ byte_data;
                    if (p % 4 == 3) begin
                        mWrEn   = 1'b1;
                        mWrAddr = BASE_ADDR + 32'(4 * (p / 4));
                        mWrData = mWord;
                        if (p == 4 * mN - 1 && !CSUM) begin
                            mActive = 1'b0; mDone = 1'b1;
                        end
                    end
                end else begin
                    mActive = 1'b0;
                    if (byte_data == mCsum) mDone = 1'b1;
                    else                    mErr  = 1'b1;
                end
                mCnt++;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("byte_ready", 32'(byte_ready), 32'(mActive));
            checkOutput("busy",       32'(busy),       32'(mActive));
            checkOutput("done",       32'(done),       32'(mDone));
            checkOutput("error",      32'(error),      32'(mErr));
            checkOutput("wr_en",      32'(wr_en),      32'(mWrEn));
            checkOutput("wr_addr",    wr_addr,         mWrAddr);
            checkOutput("wr_data",    wr_data,         mWrData);
        end
    end

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            logAddr.push_back(wr_addr);
            logData.push_back(wr_data);
            logCyc.push_back(cyc);
        end
    end

    task automatic applyStimulus(input logic st, input logic vld, input logic [7:0] d);
        @(negedge clk);
        start      = st;
        byte_valid = vld;
        byte_data  = d;
    endtask

    // Builds a stream from payload[]; csumOverride < 0 appends the correct checksum.
    task automatic buildImage(input int nField, input int csumOverride);
        logic [7:0] x;
        x = 8'h00;
        stream.delete();
        stream.push_back(8'(nField));
        stream.push_back(8'(nField >> 8));
        foreach (payload[w]) begin
            for (int b = 0; b < 4; b++) begin
                stream.push_back(payload[w][8*b +: 8]);
                x = x ^ payload[w][8*b +: 8];
            end
        end
        if (CSUM) stream.push_back(csumOverride < 0 ? x : 8'(csumOverride));
    endtask

    task automatic runSession(input int gapMax, input int gapAt, input int gapLen,
                              input int startAt, input int abortAt);
        int gap;
        applyStimulus(1'b1, 1'b0, 8'h00);
        startCyc = cyc;
        logAddr.delete(); logData.delete(); logCyc.delete();
        for (int i = 0; i < stream.size(); i++) begin
            if (i == abortAt) begin
                @(negedge clk);
                #2 rst_n = 1'b0; byte_valid = 1'b0; start = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
                repeat (2) applyStimulus(1'b0, 1'b0, 8'h00);
                return;
            end
            gap = (i == gapAt) ? gapLen : ((gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0);
            repeat (gap) applyStimulus(1'b0, 1'b0, 8'($urandom));
            applyStimulus(i == startAt, 1'b1, stream[i]);
        end
        repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkEn = 1'b1;
        checkOutput("reset_ready", 32'(byte_ready), 32'd0);
        checkOutput("reset_busy",  32'(busy),       32'd0);
        checkOutput("reset_wr_en", 32'(wr_en),      32'd0);
        checkOutput("reset_addr",  wr_addr,         32'd0);
        #2 rst_n = 1'b1;
        repeat (2) applyStimulus(1'b0, 1'b0, 8'h00);

        // Two-instruction image with correct checksum
        payload = '{32'h00A0_0513, 32'h0010_0593};
        buildImage(2, -1);
        runSession(0, -1, 0, -1, -1);
        checkOutput("plan_nwrites", 32'(logAddr.size()), 32'd2);
        if (logAddr.size() == 2) begin
            checkOutput("plan_w0_addr", logAddr[0], 32'h0);
            checkOutput("plan_w0_data", logData[0], 32'h00A0_0513);
            checkOutput("plan_w1_addr", logAddr[1], 32'h4);
            checkOutput("plan_w1_data", logData[1], 32'h0010_0593);
        end
        checkOutput("plan_done",  32'(done),  32'd1);
        checkOutput("plan_error", 32'(error), 32'd0);
        checkOutput("plan_model_done", 32'(mDone), 32'd1);

`ifdef IMEM_LOADER_CSUM_EN
        buildImage(2, 8'h00);
        runSession(0, -1, 0, -1, -1);
        checkOutput("badcsum_nwrites", 32'(logAddr.size()), 32'd2);
        checkOutput("badcsum_error",   32'(error), 32'd1);
        checkOutput("badcsum_done",    32'(done),  32'd0);
`endif

        // Illegal lengths: zero and one past capacity
        payload.delete();
        stream = '{8'h00, 8'h00};
        runSession(0, -1, 0, -1, -1);
        checkOutput("len0_error",   32'(error), 32'd1);
        checkOutput("len0_nwrites", 32'(logAddr.size()), 32'd0);
        stream = '{8'h01, 8'h04};
        runSession(0, -1, 0, -1, -1);
        checkOutput("len1025_error",   32'(error), 32'd1);
        checkOutput("len1025_done",    32'(done),  32'd0);
        checkOutput("len1025_nwrites", 32'(logAddr.size()), 32'd0);

        // Five idle cycles between payload bytes 2 and 3 of word 0
        payload = '{32'hDEAD_BEEF};
        buildImage(1, -1);
        runSession(0, 4, 5, -1, -1);
        checkOutput("gap_nwrites", 32'(logAddr.size()), 32'd1);
        if (logAddr.size() == 1) begin
            checkOutput("gap_data",    logData[0], 32'hDEAD_BEEF);
            checkOutput("gap_latency", 32'(logCyc[0] - startCyc), 32'd12);
        end
        checkOutput("gap_done", 32'(done), 32'd1);

        // Reset after 6 payload bytes of a 2-word image
        payload = '{32'h1122_3344, 32'h5566_7788};
        buildImage(2, -1);
        runSession(0, -1, 0, -1, 8);
        checkOutput("abort_nwrites", 32'(logAddr.size()), 32'd1);
        checkOutput("abort_busy",    32'(busy),  32'd0);
        checkOutput("abort_done",    32'(done),  32'd0);
        checkOutput("abort_error",   32'(error), 32'd0);
        checkOutput("abort_ready",   32'(byte_ready), 32'd0);
        checkOutput("abort_wr_data", wr_data, 32'd0);
        payload = '{32'hCAFE_F00D};
        buildImage(1, -1);
        runSession(0, -1, 0, -1, -1);
        checkOutput("reload_addr", logAddr.size() > 0 ? logAddr[0] : 32'hFFFF_FFFF, BASE_ADDR);
        checkOutput("reload_done", 32'(done), 32'd1);

        // start during DATA is ignored; restart afterwards writes from BASE again
        payload = '{32'h0101_0202, 32'h0303_0404};
        buildImage(2, -1);
        runSession(0, -1, 0, 5, -1);
        checkOutput("midstart_nwrites", 32'(logAddr.size()), 32'd2);
        checkOutput("midstart_done",    32'(done), 32'd1);
        payload = '{32'hA5A5_5A5A};
        buildImage(1, -1);
        runSession(0, -1, 0, -1, -1);
        checkOutput("restart_addr", logAddr.size() > 0 ? logAddr[0] : 32'hFFFF_FFFF, BASE_ADDR);

        // Random images, random gaps, occasionally corrupt checksum
        for (int s = 0; s < 10; s++) begin
            int n;
            n = int'($urandom_range(6, 1));
            payload.delete();
            for (int w = 0; w < n; w++) payload.push_back($urandom);
            buildImage(n, ($urandom_range(3, 0) == 0) ? int'($urandom_range(255, 0)) : -1);
            runSession(2, -1, 0, -1, -1);
            checkOutput("rand_nwrites", 32'(logAddr.size()), 32'(n));
        end

        // Full-capacity image
        payload.delete();
        for (int w = 0; w < (1 << ADDR_W); w++) payload.push_back($urandom);
        buildImage(1 << ADDR_W, -1);
        runSession(0, -1, 0, -1, -1);
        checkOutput("full_nwrites", 32'(logAddr.size()), 32'd1024);
        checkOutput("full_last_addr", logAddr.size() > 0 ? logAddr[logAddr.size()-1] : 32'hFFFF_FFFF,
                    BASE_ADDR + 32'hFFC);
        checkOutput("full_done", 32'(done), 32'd1);

        checkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
